// File: rtl/sd_buf_pkg.sv
// Shared types and defaults for the 1024-bit regfile buffer controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   SD_WORD_W / SD_HALF_W : default streaming word width and regfile half width
//   state_t               : controller state encoding
//   is_upper()            : which regfile half a state addresses
package sd_buf_pkg;

    localparam int SD_WORD_W = 32;
    localparam int SD_HALF_W = 512;

    typedef enum logic [3:0] {
        FILL_LO,
        WR_LO,
        FILL_HI,
        WR_HI,
        RD_LO,
        LD_LO,
        DRAIN_LO,
        RD_HI,
        LD_HI,
        DRAIN_HI
    } state_t;

    // Every state belongs to exactly one half of the regfile; the select
    // line follows that half so the regfile sees a stable address for the
    // whole fill/write or read/load/drain phase.
    function automatic logic is_upper(input state_t st);
        return (st == FILL_HI) || (st == WR_HI) || (st == RD_HI) ||
               (st == LD_HI)   || (st == DRAIN_HI);
    endfunction

endpackage

// File: rtl/regfile_buf_ctrl.sv
// Streams a 1024-bit block in as words, writes it to a two-half regfile, reads it back and streams it out.
// Latency: last input word accepted in cycle N -> first output word valid in cycle N+4.
// Backpressure: in_ready only while filling; out_ready low freezes the drain word and counter.
//
// Ports:
//   clk, rst             : single rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    : producer handshake, in_data is one WORD_W word
//   out_valid/out_ready  : consumer handshake, out_data is one WORD_W word
//   rf_rw, rf_sel        : regfile write strobe (1 = write) and half select (1 = upper)
//   rf_wdata, rf_rdata   : regfile half-width write and read data
//   blk_done             : pulses with the handshake of the final word of a block
module regfile_buf_ctrl
    import sd_buf_pkg::*;
#(
    parameter int WORD_W = SD_WORD_W,
    parameter int HALF_W = SD_HALF_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    input  logic              out_ready,
    output logic              rf_rw,
    output logic              rf_sel,
    output logic [HALF_W-1:0] rf_wdata,
    input  logic [HALF_W-1:0] rf_rdata,
    output logic              blk_done
);

    localparam int WPH   = HALF_W / WORD_W;
    localparam int CNT_W = (WPH > 1) ? $clog2(WPH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WPH - 1);

    state_t            state;
    logic [CNT_W-1:0]  wcnt;     // next assembly slot while filling
    logic [CNT_W-1:0]  rcnt;     // current drain slot while draining
    logic [HALF_W-1:0] asm_q;    // half being assembled from input words
    logic [HALF_W-1:0] drain_q;  // half read back from the regfile

    logic wlast;
    logic rlast;

    assign wlast = (wcnt == LAST_IDX);
    assign rlast = (rcnt == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FILL_LO;
            wcnt    <= '0;
            rcnt    <= '0;
            asm_q   <= '0;
            drain_q <= '0;
        end else begin
            case (state)
                FILL_LO, FILL_HI: begin
                    // in_ready is implied by these states, so in_valid alone
                    // marks an accepted word.
                    if (in_valid) begin
                        asm_q[int'(wcnt)*WORD_W +: WORD_W] <= in_data;
                        if (wlast) begin
                            wcnt  <= '0;
                            state <= (state == FILL_LO) ? WR_LO : WR_HI;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                WR_LO:  state <= FILL_HI;
                WR_HI:  state <= RD_LO;
                // Read address is presented for two cycles so a regfile with
                // either combinational or one-cycle registered read works.
                RD_LO:  state <= LD_LO;
                LD_LO: begin
                    drain_q <= rf_rdata;
                    state   <= DRAIN_LO;
                end
                RD_HI:  state <= LD_HI;
                LD_HI: begin
                    drain_q <= rf_rdata;
                    state   <= DRAIN_HI;
                end
                DRAIN_LO, DRAIN_HI: begin
                    if (out_ready) begin
                        if (rlast) begin
                            rcnt  <= '0;
                            state <= (state == DRAIN_LO) ? RD_HI : FILL_LO;
                        end else begin
                            rcnt <= rcnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= FILL_LO;
                    wcnt  <= '0;
                    rcnt  <= '0;
                end
            endcase
        end
    end

    assign in_ready  = (state == FILL_LO) || (state == FILL_HI);
    assign rf_rw     = (state == WR_LO) || (state == WR_HI);
    assign rf_sel    = is_upper(state);
    assign rf_wdata  = asm_q;
    assign out_valid = (state == DRAIN_LO) || (state == DRAIN_HI);

    // Forced to zero outside the drain states so the bus is quiet while idle.
    assign out_data  = out_valid ? drain_q[int'(rcnt)*WORD_W +: WORD_W] : '0;

    // A reset in the same cycle as the final handshake abandons the block,
    // so it must not be reported as completed.
    assign blk_done  = !rst && (state == DRAIN_HI) && out_ready && rlast;

endmodule
